seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seg_scan_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment display types and constants: scan FSM states and the
// active-low hex-to-segment table (bit 0 = segment a ... bit 6 = segment g).
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the pattern for hex digit n; listed F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner: each rising edge of the (synchronized)
// divided clock blanks the display for one cycle, then drives the next digit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    div_clock,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_sel
);

  logic                  sync0_q, sync1_q, prev_q, tick;
  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
  logic [NUM_DIGITS-1:0] anode_q, anode_d, sel_n;
  logic [6:0]            seg_q, seg_d, dec_seg;
  logic                  dp_n_q, dp_n_d;
  logic [3:0]            nibble;

  // div_clock is asynchronous data: two-flop synchronizer, then rising-edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= div_clock;
      sync1_q <= sync0_q;
      prev_q  <= sync1_q;
    end
  end

  assign tick    = sync1_q & ~prev_q;
  assign idx_nxt = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  assign nibble  = value[{idx_q, 2'b00} +: 4];

  hex_to_seg u_dec (
    .hex   (nibble),
    .seg_n (dec_seg)
  );

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) sel_n[i] = (idx_q != IDX_W'(i));
  end

  // The output registers double as the latch for the digit sampled in BLANK,
  // so DRIVE simply holds them until the next tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_n_d  = dp_n_q;
    case (state_q)
      IDLE: begin
        anode_d = '1;
        seg_d   = SEG_BLANK;
        dp_n_d  = 1'b1;
        if (tick) state_d = BLANK;
      end
      BLANK: begin
        if (tick) begin
          idx_d   = idx_nxt;
          anode_d = '1;
          seg_d   = SEG_BLANK;
          dp_n_d  = 1'b1;
        end else begin
          state_d = DRIVE;
          anode_d = digit_en[idx_q] ? sel_n : '1;
          seg_d   = digit_en[idx_q] ? dec_seg : SEG_BLANK;
          dp_n_d  = ~dp[idx_q];
        end
      end
      DRIVE: begin
        if (tick) begin
          state_d = BLANK;
          idx_d   = idx_nxt;
          anode_d = '1;
          seg_d   = SEG_BLANK;
          dp_n_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        anode_d = '1;
        seg_d   = SEG_BLANK;
        dp_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      dp_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign anode     = anode_q;
  assign seg       = seg_q;
  assign dp_n      = dp_n_q;
  assign digit_sel = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: each div_clock rise pushes the expected
// digit slot, which is popped and compared when the DUT drives it.
module tb_seg_scan_driver;

  localparam int ND = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          div_clock = 1'b0;
  logic [4*ND-1:0] value = '0;
  logic [ND-1:0] digit_en = '0;
  logic [ND-1:0] dp = '0;
  logic [ND-1:0] anode;
  logic [6:0]    seg;
  logic          dp_n;
  logic [1:0]    digit_sel;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp_n;
    logic [1:0] sel;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   idx_m   = 0;
  bit   started = 1'b0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.NUM_DIGITS(ND)) dut (
    .clock     (clock),
    .reset     (reset),
    .div_clock (div_clock),
    .value     (value),
    .digit_en  (digit_en),
    .dp        (dp),
    .anode     (anode),
    .seg       (seg),
    .dp_n      (dp_n),
    .digit_sel (digit_sel)
  );

  always #5 clock = ~clock;

  // Reference model of the next digit slot, evaluated when the tick is launched.
  function automatic void push_exp();
    exp_t e;
    logic [3:0] nib;
    if (started) idx_m = (idx_m == ND - 1) ? 0 : idx_m + 1;
    started = 1'b1;
    nib   = value[idx_m*4 +: 4];
    e.sel = 2'(idx_m);
    e.dp_n = ~dp[idx_m];
    if (digit_en[idx_m]) begin
      e.anode = ~(4'b0001 << idx_m);
      e.seg   = seg_tbl[nib];
    end else begin
      e.anode = 4'hF;
      e.seg   = 7'h7F;
    end
    q.push_back(e);
  endfunction

  // One scan slot: div_clock high for 4 samples then low for lo samples.
  task automatic run_slot(input int lo, input bit rel);
    exp_t e;
    push_exp();
    @(negedge clock);
    if (rel) reset = 1'b0;
    div_clock = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_sel !== q[0].sel) begin
      n_fail++;
      $display("FAIL blank: got anode=%h seg=%h dp_n=%b sel=%0d, want F/7f/1/%0d",
               anode, seg, dp_n, digit_sel, q[0].sel);
    end
    @(negedge clock);
    e = q.pop_front();
    n_tests++;
    if ({anode, seg, dp_n, digit_sel} !== e) begin
      n_fail++;
      $display("FAIL drive: got anode=%b seg=%h dp_n=%b sel=%0d, want %b/%h/%b/%0d",
               anode, seg, dp_n, digit_sel, e.anode, e.seg, e.dp_n, e.sel);
    end
    div_clock = 1'b0;
    repeat (lo) @(negedge clock);
    n_tests++;
    if ({anode, seg, dp_n, digit_sel} !== e) begin
      n_fail++;
      $display("FAIL hold: got anode=%b seg=%h dp_n=%b sel=%0d, want %b/%h/%b/%0d",
               anode, seg, dp_n, digit_sel, e.anode, e.seg, e.dp_n, e.sel);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_tests++;
    if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got anode=%h seg=%h dp_n=%b sel=%0d, want F/7f/1/0",
               anode, seg, dp_n, digit_sel);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (anode !== 4'hF || seg !== 7'h7F || digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_dark: got anode=%h seg=%h sel=%0d, want F/7f/0", anode, seg, digit_sel);
    end
  endtask

  task automatic test_first_tick();
    value = 16'h1234; digit_en = 4'hF; dp = 4'h0;
    run_slot(4, 1'b0);
  endtask

  task automatic test_scan();
    for (int i = 0; i < 4; i++) run_slot(4, 1'b0);
  endtask

  task automatic test_enable();
    value = 16'hABCD; digit_en = 4'b0101;
    for (int i = 0; i < 4; i++) run_slot(4, 1'b0);
  endtask

  task automatic test_dp();
    value = 16'h1234; digit_en = 4'hF; dp = 4'b0010;
    for (int i = 0; i < 4; i++) run_slot(4, 1'b0);
    dp = 4'h0;
  endtask

  task automatic test_decode();
    logic [3:0] hv;
    digit_en = 4'hF;
    for (int h = 0; h < 16; h++) begin
      hv = 4'(h);
      value = {hv, hv, hv, hv};
      run_slot(3, 1'b0);
    end
  endtask

  // div_clock toggles every cycle: a tick every 2 clocks, so the DUT alternates
  // BLANK/DRIVE. A rise driven at negedge c is dark at c+3 and driven at c+4.
  task automatic test_div2();
    exp_t e;
    value = 16'h9E5C; digit_en = 4'hF;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clock);
      if (c % 2 == 1 && c >= 3) begin
        n_tests++;
        if (anode !== 4'hF || seg !== 7'h7F || digit_sel !== q[0].sel) begin
          n_fail++;
          $display("FAIL div2_blank c=%0d: got anode=%h seg=%h sel=%0d, want F/7f/%0d",
                   c, anode, seg, digit_sel, q[0].sel);
        end
      end
      if (c % 2 == 0 && c >= 4) begin
        e = q.pop_front();
        n_tests++;
        if ({anode, seg, dp_n, digit_sel} !== e) begin
          n_fail++;
          $display("FAIL div2_drive c=%0d: got anode=%b seg=%h sel=%0d, want %b/%h/%0d",
                   c, anode, seg, digit_sel, e.anode, e.seg, e.sel);
        end
      end
      if (c < 12 && c % 2 == 0) begin
        push_exp();
        div_clock = 1'b1;
      end else begin
        div_clock = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    value = 16'h5678; digit_en = 4'hF;
    for (int g = 0; g < 4 && idx_m != 2; g++) run_slot(4, 1'b0);
    n_tests++;
    if (digit_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_sel: got %0d, want 2", digit_sel);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (anode !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got anode=%h seg=%h dp_n=%b sel=%0d, want F/7f/1/0",
               anode, seg, dp_n, digit_sel);
    end
    div_clock = 1'b1;
    @(negedge clock);
    started = 1'b0;
    idx_m   = 0;
    // Released with div_clock already high: that alone must produce a tick to digit 0.
    run_slot(4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_scan();
    test_enable();
    test_dp();
    test_decode();
    test_div2();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
